// File: rtl/break_value_collector_if.sv
// Occurrence-record stream and result handshake between the break value collector and its neighbours.
// The master side drives records and acknowledges results. The slave side (the collector) consumes records and presents results.
interface break_value_collector_if #(
  parameter int NSAT      = 3,
  parameter int MCB       = 5,
  parameter int NSAT_BITS = $clog2(NSAT)
);
  logic                  occ_valid_i;
  logic                  occ_ready_o;
  logic [NSAT_BITS-1:0]  occ_slot_i;
  logic                  occ_critical_i;
  logic                  occ_last_i;
  logic [NSAT*MCB-1:0]   break_values_o;
  logic [NSAT-1:0]       break_values_valid_o;
  logic                  done_o;
  logic                  result_ack_i;

  modport master (
    output occ_valid_i, occ_slot_i, occ_critical_i, occ_last_i, result_ack_i,
    input  occ_ready_o, break_values_o, break_values_valid_o, done_o
  );

  modport slave (
    input  occ_valid_i, occ_slot_i, occ_critical_i, occ_last_i, result_ack_i,
    output occ_ready_o, break_values_o, break_values_valid_o, done_o
  );
endinterface

// File: rtl/break_value_collector.sv
// Counts critical occurrences (the break value) per literal slot of the chosen unsatisfied clause.
// Optional macro BREAK_OVERFLOW_FLAG_EN adds sticky per-slot saturation flags on overflow_o.
module break_value_collector #(
  parameter int MAX_CLAUSES_PER_VARIABLE = 20,
  parameter int NSAT                     = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_i,
  input  logic [NSAT-1:0]          slot_mask_i,
  break_value_collector_if.slave   bus,
  output logic                     busy_o,
  output logic                     error_o
`ifdef BREAK_OVERFLOW_FLAG_EN
  ,
  output logic [NSAT-1:0]          overflow_o
`endif
);
  localparam int MCB       = $clog2(MAX_CLAUSES_PER_VARIABLE);
  localparam int NSAT_BITS = $clog2(NSAT);
  localparam logic [MCB-1:0] CNT_MAX = {MCB{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NSAT-1:0]     mask_q, mask_d;
  logic [NSAT-1:0]     pending_q, pending_d;
  logic [NSAT-1:0]     valid_q, valid_d;
  logic [NSAT*MCB-1:0] counts_q, counts_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;
  logic                error_q, error_d;
  logic [NSAT-1:0]     ovf_q, ovf_d;
  logic [NSAT-1:0]     slot_sel_s;
  logic                accept_s;
  logic                rec_ok_s;

  always_comb begin
    for (int k = 0; k < NSAT; k++) begin
      slot_sel_s[k] = (bus.occ_slot_i == NSAT_BITS'(k));
    end
    accept_s  = (state_q == S_COLLECT) && bus.occ_valid_i && ready_q;
    // A record is only legal for a slot that is still pending; this also rejects out-of-range and unmasked slots.
    rec_ok_s  = |(slot_sel_s & pending_q);

    state_d   = state_q;
    mask_d    = mask_q;
    pending_d = pending_q;
    counts_d  = counts_q;
    error_d   = error_q;
    ovf_d     = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mask_d    = slot_mask_i;
          pending_d = slot_mask_i;
          counts_d  = '0;
          error_d   = 1'b0;
          ovf_d     = '0;
          state_d   = (slot_mask_i != '0) ? S_COLLECT : S_DONE;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (accept_s && rec_ok_s) begin
          for (int k = 0; k < NSAT; k++) begin
            if (slot_sel_s[k]) begin
              if (bus.occ_critical_i && (counts_q[k*MCB +: MCB] != CNT_MAX)) begin
                counts_d[k*MCB +: MCB] = counts_q[k*MCB +: MCB] + MCB'(1);
              end else if (bus.occ_critical_i) begin
                ovf_d[k] = 1'b1;
              end else begin
                counts_d[k*MCB +: MCB] = counts_q[k*MCB +: MCB];
              end
              if (bus.occ_last_i) begin
                pending_d[k] = 1'b0;
              end else begin
                pending_d[k] = pending_q[k];
              end
            end else begin
              pending_d[k] = pending_q[k];
            end
          end
        end else if (accept_s) begin
          error_d = 1'b1;
        end else begin
          error_d = error_q;
        end
        state_d = (pending_d == '0) ? S_DONE : S_COLLECT;
      end
      S_DONE: begin
        if (bus.result_ack_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so that they change on the same edge as the state.
    ready_d = (state_d == S_COLLECT);
    done_d  = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_DONE) ? mask_d : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      pending_q <= '0;
      valid_q   <= '0;
      counts_q  <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      ovf_q     <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      counts_q  <= counts_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.occ_ready_o          = ready_q;
  assign bus.break_values_o       = counts_q;
  assign bus.break_values_valid_o = valid_q;
  assign bus.done_o               = done_q;
  assign busy_o                   = busy_q;
  assign error_o                  = error_q;
`ifdef BREAK_OVERFLOW_FLAG_EN
  assign overflow_o               = ovf_q;
`else
  logic unused_ovf_s;
  assign unused_ovf_s             = ^ovf_q;
`endif
endmodule

// File: tb/tb_break_value_collector.sv
// Scoreboard bench for break_value_collector: the driver pushes model results, and a monitor compares them on each done_o rise.
module tb_break_value_collector;
  localparam int NSAT = 3;
  localparam int MCB  = 5;
  localparam int CMAX = 31;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start_i;
  logic [2:0] slot_mask_i;
  logic       busy_o;
  logic       error_o;
`ifdef BREAK_OVERFLOW_FLAG_EN
  logic [2:0] overflow_o;
`endif

  break_value_collector_if #(.NSAT(NSAT), .MCB(MCB)) bus ();

  break_value_collector #(.MAX_CLAUSES_PER_VARIABLE(20), .NSAT(NSAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .slot_mask_i (slot_mask_i),
    .bus         (bus),
    .busy_o      (busy_o),
    .error_o     (error_o)
`ifdef BREAK_OVERFLOW_FLAG_EN
    ,
    .overflow_o  (overflow_o)
`endif
  );

  typedef struct {
    int slot;
    bit crit;
    bit last;
  } rec_t;

  typedef struct {
    logic [14:0] bv;
    logic [2:0]  vld;
    logic        err;
    logic [2:0]  ovf;
  } exp_t;

  rec_t seq[$];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: walk the record list, track which slots are still open, and sum criticals with plain integers.
  function automatic exp_t model(input logic [2:0] mask);
    exp_t e;
    int   raw [3];
    bit   open[3];
    for (int k = 0; k < 3; k++) begin
      raw[k]  = 0;
      open[k] = mask[k];
    end
    e.err = 1'b0;
    foreach (seq[i]) begin
      if (seq[i].slot < 3 && open[seq[i].slot]) begin
        raw[seq[i].slot] += int'(seq[i].crit);
        if (seq[i].last) open[seq[i].slot] = 1'b0;
      end else begin
        e.err = 1'b1;
      end
    end
    for (int k = 0; k < 3; k++) begin
      e.bv[k*5 +: 5] = (raw[k] > CMAX) ? 5'd31 : 5'(raw[k]);
      e.ovf[k]       = (raw[k] > CMAX);
    end
    e.vld = mask;
    return e;
  endfunction

  task automatic mon_compare();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_done", {31'd0, bus.done_o}, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("break_values", {17'd0, bus.break_values_o}, {17'd0, e.bv});
      check("valid_mask", {29'd0, bus.break_values_valid_o}, {29'd0, e.vld});
      check("error_flag", {31'd0, error_o}, {31'd0, e.err});
      check("busy_in_done", {31'd0, busy_o}, 32'd1);
`ifdef BREAK_OVERFLOW_FLAG_EN
      check("overflow_flags", {29'd0, overflow_o}, {29'd0, e.ovf});
`endif
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.done_o && !prev_done) mon_compare();
    prev_done <= bus.done_o;
  end

  task automatic start_txn(input logic [2:0] m, output int t0);
    start_i     = 1'b1;
    slot_mask_i = m;
    @(negedge clk);
    start_i     = 1'b0;
    slot_mask_i = 3'($urandom);
    t0          = cyc;
  endtask

  task automatic send_rec(input rec_t r);
    int n = 0;
    bus.occ_valid_i    = 1'b1;
    bus.occ_slot_i     = 2'(r.slot);
    bus.occ_critical_i = r.crit;
    bus.occ_last_i     = r.last;
    while (!bus.occ_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("occ_ready_wait", {31'd0, bus.occ_ready_o}, 32'd1);
    @(negedge clk);
    bus.occ_valid_i = 1'b0;
  endtask

  task automatic run_txn(input logic [2:0] m, input bit gaps, output int lat);
    int t0;
    int n = 0;
    exp_q.push_back(model(m));
    start_txn(m, t0);
    foreach (seq[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_rec(seq[i]);
    end
    while (!bus.done_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_wait", {31'd0, bus.done_o}, 32'd1);
    lat = cyc - t0 + 1;
  endtask

  task automatic ack_txn(input int hold);
    repeat (hold) @(negedge clk);
    bus.result_ack_i = 1'b1;
    @(negedge clk);
    bus.result_ack_i = 1'b0;
    check("done_drop_after_ack", {31'd0, bus.done_o}, 32'd0);
    check("valid_clear_after_ack", {29'd0, bus.break_values_valid_o}, 32'd0);
  endtask

  task automatic push_rec(input int s, input bit c, input bit l);
    rec_t r;
    r.slot = s;
    r.crit = c;
    r.last = l;
    seq.push_back(r);
  endtask

  task automatic gen_seq(input logic [2:0] m);
    int   left[3];
    int   k;
    int   nbad;
    rec_t r;
    seq.delete();
    for (int s = 0; s < 3; s++) begin
      if (!m[s])                        left[s] = 0;
      else if ($urandom_range(0, 7) == 0) left[s] = $urandom_range(30, 40);
      else                              left[s] = $urandom_range(1, 8);
    end
    while (left[0] + left[1] + left[2] > 0) begin
      k = $urandom_range(0, 2);
      if (left[k] > 0) begin
        push_rec(k, ($urandom_range(0, 3) != 0), (left[k] == 1));
        left[k]--;
      end
    end
    // Illegal records go anywhere before the final one, which must be the one that closes the collection.
    nbad = (seq.size() == 0) ? 0 : $urandom_range(0, 2);
    for (int b = 0; b < nbad; b++) begin
      r.slot = 3;
      if (m != 3'b111 && $urandom_range(0, 1) == 1) begin
        do r.slot = $urandom_range(0, 2); while (m[r.slot]);
      end
      r.crit = 1'b1;
      r.last = $urandom_range(0, 1) == 1;
      seq.insert($urandom_range(0, seq.size() - 1), r);
    end
  endtask

  initial begin
    int lat;
    int t0;
    logic [2:0] m;
    reset = 1'b1;
    start_i = 1'b0;
    slot_mask_i = 3'b000;
    bus.occ_valid_i = 1'b0;
    bus.occ_slot_i = 2'd0;
    bus.occ_critical_i = 1'b0;
    bus.occ_last_i = 1'b0;
    bus.result_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_done", {31'd0, bus.done_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_ready", {31'd0, bus.occ_ready_o}, 32'd0);
    check("rst_error", {31'd0, error_o}, 32'd0);
    check("rst_counts", {17'd0, bus.break_values_o}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    seq.delete();
    push_rec(0, 1'b1, 1'b0); push_rec(0, 1'b1, 1'b0); push_rec(0, 1'b0, 1'b1);
    push_rec(1, 1'b0, 1'b1); push_rec(2, 1'b1, 1'b1);
    run_txn(3'b111, 1'b1, lat);
    check("basic_counts", {17'd0, bus.break_values_o}, {17'd0, 5'd1, 5'd0, 5'd2});
    ack_txn(2);

    seq.delete();
    run_txn(3'b000, 1'b0, lat);
    check("zero_mask_latency", lat, 32'd1);
    ack_txn(0);

    seq.delete();
    push_rec(1, 1'b1, 1'b0); push_rec(0, 1'b1, 1'b1); push_rec(0, 1'b1, 1'b0);
    push_rec(3, 1'b1, 1'b1); push_rec(2, 1'b0, 1'b1);
    run_txn(3'b101, 1'b1, lat);
    ack_txn(1);
    check("error_sticky_in_idle", {31'd0, error_o}, 32'd1);

    seq.delete();
    for (int i = 0; i < 40; i++) push_rec(0, 1'b1, (i == 39));
    run_txn(3'b001, 1'b0, lat);
    check("saturated_count", {27'd0, bus.break_values_o[4:0]}, 32'd31);
    ack_txn(0);

    start_txn(3'b111, t0);
    seq.delete();
    push_rec(0, 1'b1, 1'b0); push_rec(1, 1'b1, 1'b0); push_rec(2, 1'b1, 1'b0);
    foreach (seq[i]) send_rec(seq[i]);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    check("midrst_ready", {31'd0, bus.occ_ready_o}, 32'd0);
    check("midrst_counts", {17'd0, bus.break_values_o}, 32'd0);
    check("midrst_done", {31'd0, bus.done_o}, 32'd0);
    reset = 1'b0;
    seq.delete();
    push_rec(1, 1'b1, 1'b1);
    run_txn(3'b010, 1'b0, lat);
    check("min_latency", lat, 32'd2);
    ack_txn(0);

    seq.delete();
    push_rec(2, 1'b1, 1'b1);
    run_txn(3'b100, 1'b0, lat);
    bus.occ_valid_i = 1'b1;
    bus.occ_slot_i  = 2'd2;
    bus.occ_critical_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_ready", {31'd0, bus.occ_ready_o}, 32'd0);
      check("hold_done", {31'd0, bus.done_o}, 32'd1);
      check("hold_counts", {17'd0, bus.break_values_o}, {17'd0, 5'd1, 5'd0, 5'd0});
    end
    bus.occ_valid_i = 1'b0;
    bus.result_ack_i = 1'b1;
    start_i = 1'b1;
    slot_mask_i = 3'b111;
    @(negedge clk);
    bus.result_ack_i = 1'b0;
    start_i = 1'b0;
    check("ack_start_done", {31'd0, bus.done_o}, 32'd0);
    check("ack_start_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    check("start_ignored_busy", {31'd0, busy_o}, 32'd0);
    check("start_ignored_ready", {31'd0, bus.occ_ready_o}, 32'd0);

    for (int t = 0; t < 25; t++) begin
      m = 3'($urandom_range(0, 7));
      gen_seq(m);
      run_txn(m, 1'b1, lat);
      ack_txn($urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end
endmodule
